// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element datapath: the partial-sum
// width, the partial-sum buffer state encoding and a ReLU clamp helper.
package pe_pkg;

    localparam int PSUM_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } psum_buf_state_t;

    // Negative sums (MSB set) clamp to zero; non-negative sums pass unchanged.
    function automatic logic [PSUM_W-1:0] relu_clamp(input logic [PSUM_W-1:0] v);
        logic [PSUM_W-1:0] r;
        if (v[PSUM_W-1] == 1'b1) begin
            r = {PSUM_W{1'b0}};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_mem.sv
// DEPTH x PSUM_W partial-sum register file: one combinational read port,
// one synchronous write port. Contents are intentionally not reset.
module psum_mem
    import pe_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PSUM_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PSUM_W-1:0] rd_data
);

    logic [PSUM_W-1:0] mem_q [DEPTH];

    // Synchronous write of one entry per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/psum_buffer.sv
// Partial-sum buffer for one weight-stationary INT8 MAC column.
// Feeds stored sums to the MAC during a pass, writes back the MAC's
// registered result one cycle later, and drains the final sums over a
// valid/ready stream.
// Optional feature: define PSUM_BUF_RELU_EN to clamp negative drained
// values to zero (stored contents are left untouched).
module psum_buffer
    import pe_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              first_pass,
    input  logic              last_pass,
    input  logic              acc_valid,
    output logic [PSUM_W-1:0] mac_psum_in,
    input  logic [PSUM_W-1:0] mac_psum_out,
    output logic              drain_valid,
    input  logic              drain_ready,
    output logic [PSUM_W-1:0] drain_data,
    output logic              drain_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    psum_buf_state_t   state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] mem_rd_addr_s;
    logic [PSUM_W-1:0] mem_rd_data_s;
    logic              mem_wr_en_s;

    // A write-back pending in a reset cycle is dropped.
    assign mem_wr_en_s = wr_en_q & ~rst;

    psum_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en_s),
        .wr_addr (wr_addr_q),
        .wr_data (mac_psum_out),
        .rd_addr (mem_rd_addr_s),
        .rd_data (mem_rd_data_s)
    );

    // Next-state logic: pass sequencing, address counters and write-back capture.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        drain_addr_d = drain_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_en_d      = 1'b0;
        first_d      = first_q;
        last_d       = last_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    first_d   = first_pass;
                    last_d    = last_pass;
                    rd_addr_d = {ADDR_W{1'b0}};
                    state_d   = ACCUM;
                end else begin
                    state_d   = IDLE;
                end
            end
            ACCUM: begin
                if (acc_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = rd_addr_q;
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_d = {ADDR_W{1'b0}};
                        state_d   = FLUSH;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            FLUSH: begin
                if (last_q) begin
                    drain_addr_d = {ADDR_W{1'b0}};
                    state_d      = DRAIN;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (drain_ready) begin
                    if (drain_addr_q == LAST_ADDR) begin
                        drain_addr_d = {ADDR_W{1'b0}};
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        drain_addr_d = drain_addr_q + ADDR_W'(1);
                        state_d      = DRAIN;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: read-port steering and state-qualified outputs.
    always_comb begin
        mem_rd_addr_s = rd_addr_q;
        mac_psum_in   = {PSUM_W{1'b0}};
        drain_valid   = 1'b0;
        drain_data    = {PSUM_W{1'b0}};
        drain_last    = 1'b0;
        if (state_q == DRAIN) begin
            mem_rd_addr_s = drain_addr_q;
            drain_valid   = 1'b1;
`ifdef PSUM_BUF_RELU_EN
            drain_data    = relu_clamp(mem_rd_data_s);
`else
            drain_data    = mem_rd_data_s;
`endif
            drain_last    = (drain_addr_q == LAST_ADDR);
        end else if ((state_q == ACCUM) && !first_q) begin
            mac_psum_in   = mem_rd_data_s;
        end else begin
            mac_psum_in   = {PSUM_W{1'b0}};
        end
        busy = (state_q != IDLE);
        done = done_q;
    end

    // State register with synchronous reset; memory contents are not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_addr_q    <= {ADDR_W{1'b0}};
            drain_addr_q <= {ADDR_W{1'b0}};
            wr_addr_q    <= {ADDR_W{1'b0}};
            wr_en_q      <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            drain_addr_q <= drain_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            first_q      <= first_d;
            last_q       <= last_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_psum_buffer.sv
// Self-checking bench for psum_buffer (DEPTH = 4). A registered MAC stand-in
// adds a bench-chosen increment to mac_psum_in; an array of expected entry
// values tracks what each pass must leave in the buffer.
module tb_psum_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        first_pass;
    logic        last_pass;
    logic        acc_valid;
    logic [31:0] mac_psum_in;
    logic [31:0] mac_psum_out;
    logic        drain_valid;
    logic        drain_ready;
    logic [31:0] drain_data;
    logic        drain_last;
    logic        busy;
    logic        done;

    logic [31:0] mac_add;
    logic [31:0] model [DEPTH];
    logic [31:0] adds  [DEPTH];
    bit          pat_q [$];
    int          checks;
    int          failures;

    psum_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .first_pass   (first_pass),
        .last_pass    (last_pass),
        .acc_valid    (acc_valid),
        .mac_psum_in  (mac_psum_in),
        .mac_psum_out (mac_psum_out),
        .drain_valid  (drain_valid),
        .drain_ready  (drain_ready),
        .drain_data   (drain_data),
        .drain_last   (drain_last),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAC stand-in: registered psum_out; garbage when no step so stray writes show up.
    always @(posedge clk) begin
        mac_psum_out <= acc_valid ? (mac_psum_in + mac_add) : 32'hDEAD_BEEF;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] exp_drain(input logic [31:0] v);
`ifdef PSUM_BUF_RELU_EN
        return ($signed(v) < 0) ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accumulation pass; acc_valid comes from pat_q first, then random bubbles.
    task automatic do_pass(input bit first, input bit last, input int bubble_pct, input bit glitch);
        int          k;
        int          cyc;
        bit          av;
        logic [31:0] exp_in;
        start      = 1'b1;
        first_pass = first;
        last_pass  = last;
        tick();
        start      = 1'b0;
        first_pass = ~first;
        last_pass  = ~last;
        check("busy_accum", 32'(busy), 32'd1);
        k   = 0;
        cyc = 0;
        while (k < DEPTH && cyc < 200) begin
            if (pat_q.size() > 0) av = pat_q.pop_front();
            else                  av = ($urandom_range(99) >= bubble_pct);
            exp_in = first ? 32'd0 : model[k];
            check("mac_psum_in", mac_psum_in, exp_in);
            acc_valid = av;
            mac_add   = adds[k];
            if (glitch && cyc == 1) begin
                start      = 1'b1;
                first_pass = 1'b1;
            end
            tick();
            acc_valid = 1'b0;
            start     = 1'b0;
            if (av) begin
                model[k] = exp_in + adds[k];
                k++;
            end
            cyc++;
        end
        check("accum_steps", 32'(k), 32'(DEPTH));
        // FLUSH cycle: acc_valid here must be ignored.
        check("flush_busy", 32'(busy), 32'd1);
        check("flush_done", 32'(done), 32'd0);
        check("flush_mac_in", mac_psum_in, 32'd0);
        acc_valid = 1'b1;
        mac_add   = 32'h0000_1234;
        tick();
        acc_valid = 1'b0;
        if (!last) begin
            check("pass_done", 32'(done), 32'd1);
            check("pass_idle", 32'(busy), 32'd0);
            tick();
            check("done_pulse_end", 32'(done), 32'd0);
        end else begin
            check("enter_drain", 32'(drain_valid), 32'd1);
        end
    endtask

    // Drain entries; optional stall on one entry; stop_after >= 0 returns early.
    task automatic drain(input int ready_pct, input int stall_idx, input int stall_cycles, input int stop_after);
        int idx;
        int cyc;
        int stall;
        bit rdy;
        idx   = 0;
        cyc   = 0;
        stall = 0;
        while (idx < DEPTH && cyc < 500) begin
            check("drain_valid", 32'(drain_valid), 32'd1);
            check("drain_data", drain_data, exp_drain(model[idx]));
            check("drain_last", 32'(drain_last), 32'(idx == DEPTH - 1));
            check("drain_done_low", 32'(done), 32'd0);
            if (idx == stop_after) return;
            if (idx == stall_idx && stall < stall_cycles) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = ($urandom_range(99) < ready_pct);
            end
            drain_ready = rdy;
            tick();
            drain_ready = 1'b0;
            if (rdy) idx++;
            cyc++;
        end
        check("drain_count", 32'(idx), 32'(DEPTH));
        if (ready_pct == 100 && stall_cycles == 0) check("drain_cycles", 32'(cyc), 32'(DEPTH));
        check("drain_end_done", 32'(done), 32'd1);
        check("drain_end_busy", 32'(busy), 32'd0);
        check("drain_end_valid", 32'(drain_valid), 32'd0);
        check("drain_end_data", drain_data, 32'd0);
        tick();
        check("drain_done_pulse_end", 32'(done), 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        first_pass  = 1'b0;
        last_pass   = 1'b0;
        acc_valid   = 1'b0;
        drain_ready = 1'b0;
        mac_add     = 32'd0;

        // Reset held for two cycles.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_drain_valid", 32'(drain_valid), 32'd0);
        check("rst_drain_data", drain_data, 32'd0);
        check("rst_drain_last", 32'(drain_last), 32'd0);
        check("rst_mac_in", mac_psum_in, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // First pass: MAC returns 10,20,30,40 from zero inputs.
        for (int i = 0; i < DEPTH; i++) adds[i] = 32'(10 * (i + 1));
        do_pass(1'b1, 1'b0, 0, 1'b0);

        // Accumulate +5 and drain 15,25,35,45; start pulsed mid-pass is ignored.
        for (int i = 0; i < DEPTH; i++) adds[i] = 32'd5;
        do_pass(1'b0, 1'b1, 0, 1'b1);
        drain(100, -1, 0, -1);

        // Bubble pattern 1,0,0,1,1,0,1 then a 3-cycle stall on entry 1.
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < DEPTH; i++) adds[i] = 32'(i + 1);
        do_pass(1'b0, 1'b1, 0, 1'b0);
        drain(100, 1, 3, -1);

        // Randomised passes with random bubbles and random backpressure.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < DEPTH; i++) adds[i] = $urandom;
            do_pass(1'($urandom_range(1)), 1'b1, 35, 1'($urandom_range(1)));
            drain(60, -1, 0, -1);
        end
        for (int i = 0; i < DEPTH; i++) adds[i] = $urandom_range(1000);
        do_pass(1'b0, 1'b0, 20, 1'b0);

        // Reset in the middle of DRAIN, then a fresh pass.
        for (int i = 0; i < DEPTH; i++) adds[i] = $urandom;
        do_pass(1'b0, 1'b1, 20, 1'b0);
        drain(100, -1, 0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_valid", 32'(drain_valid), 32'd0);
        check("midrst_data", drain_data, 32'd0);
        tick();
        check("midrst_done_later", 32'(done), 32'd0);
        for (int i = 0; i < DEPTH; i++) adds[i] = $urandom;
        do_pass(1'b1, 1'b1, 30, 1'b0);
        drain(70, -1, 0, -1);

        // Sign handling on drain: -7, 3, 100, -1.
        adds[0] = 32'hFFFF_FFF9;
        adds[1] = 32'd3;
        adds[2] = 32'd100;
        adds[3] = 32'hFFFF_FFFF;
        do_pass(1'b1, 1'b1, 0, 1'b0);
        drain(100, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
